// File: rtl/ex_mem_pkg.sv
// Shared widths, control-bit positions and the default EX/MEM entry layout.
// The optional branch resolution feature is selected with EX_MEM_BRANCH_RESOLVE_EN.
package ex_mem_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_WB_W       = 2;
  localparam int DEF_MEM_W      = 3;

  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  localparam int MEM_BRANCH = 2;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;

  typedef struct packed {
    logic [DEF_DATA_W-1:0]     pc_beq;
    logic [DEF_DATA_W-1:0]     alu_result;
    logic [DEF_DATA_W-1:0]     read_data_2;
    logic [DEF_REG_ADDR_W-1:0] write_register;
    logic                      alu_zero;
    logic [DEF_WB_W-1:0]       WB;
    logic [DEF_MEM_W-1:0]      MEM;
  } ex_mem_entry_t;

endpackage

// File: rtl/ex_mem_skid.sv
// Generic 2-slot elastic buffer (main + skid) with full throughput and strict FIFO order.
// flush drops both slots; drop_skid discards only the skid entry while main is consumed.
module ex_mem_skid
  import ex_mem_pkg::*;
#(
  parameter type entry_t = ex_mem_entry_t
) (
  input  logic   clock,
  input  logic   startin,
  input  logic   flush,
  input  logic   drop_skid,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_data
);

  logic   main_valid;
  logic   skid_valid;
  entry_t main_data;
  entry_t skid_data;
  logic   accept;
  logic   main_load;

  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign main_load = !main_valid || out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  // The skid slot only fills when main is stalled, so in_ready can be a plain register decode.
  always_ff @(posedge clock or posedge startin) begin
    if (startin) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (main_load) begin
        if (skid_valid && !drop_skid) begin
          main_data  <= skid_data;
          main_valid <= 1'b1;
        end else if (accept) begin
          main_data  <= in_data;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end
      if (drop_skid || (skid_valid && main_load)) begin
        skid_valid <= 1'b0;
      end else if (accept && !main_load) begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready skid buffering, sync flush and bubble masking.
// Define EX_MEM_BRANCH_RESOLVE_EN to add pc_src_output/pc_target_output and taken-branch skid drop.
module ex_mem_pipe_reg
  import ex_mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int WB_W       = DEF_WB_W,
  parameter int MEM_W      = DEF_MEM_W
) (
  input  logic                  clock,
  input  logic                  startin,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     pc_beq_input,
  input  logic [DATA_W-1:0]     alu_result_input,
  input  logic [DATA_W-1:0]     read_data_2_input,
  input  logic [REG_ADDR_W-1:0] write_register_input,
  input  logic                  alu_zero_input,
  input  logic [WB_W-1:0]       WB_input,
  input  logic [MEM_W-1:0]      MEM_input,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     pc_beq_output,
  output logic [DATA_W-1:0]     alu_result_output,
  output logic [DATA_W-1:0]     read_data_2_output,
  output logic [REG_ADDR_W-1:0] write_register_output,
  output logic                  alu_zero_output,
  output logic [WB_W-1:0]       WB_output,
  output logic [MEM_W-1:0]      MEM_output
`ifdef EX_MEM_BRANCH_RESOLVE_EN
  ,
  output logic                  pc_src_output,
  output logic [DATA_W-1:0]     pc_target_output
`endif
);

  // Local entry layout so non-default parameter widths are carried without truncation.
  typedef struct packed {
    logic [DATA_W-1:0]     pc_beq;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     read_data_2;
    logic [REG_ADDR_W-1:0] write_register;
    logic                  alu_zero;
    logic [WB_W-1:0]       WB;
    logic [MEM_W-1:0]      MEM;
  } entry_t;

  entry_t in_entry;
  entry_t out_entry;
  logic   drop_skid;

  assign in_entry.pc_beq         = pc_beq_input;
  assign in_entry.alu_result     = alu_result_input;
  assign in_entry.read_data_2    = read_data_2_input;
  assign in_entry.write_register = write_register_input;
  assign in_entry.alu_zero       = alu_zero_input;
  assign in_entry.WB             = WB_input;
  assign in_entry.MEM            = MEM_input;

  ex_mem_skid #(
    .entry_t(entry_t)
  ) u_skid (
    .clock    (clock),
    .startin  (startin),
    .flush    (flush),
    .drop_skid(drop_skid),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_entry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_entry)
  );

  assign pc_beq_output         = out_entry.pc_beq;
  assign alu_result_output     = out_entry.alu_result;
  assign read_data_2_output    = out_entry.read_data_2;
  assign write_register_output = out_entry.write_register;
  assign alu_zero_output       = out_entry.alu_zero;

  // Bubbles must never carry live control into MEM/WB, even though data is left stale.
  assign WB_output  = out_valid ? out_entry.WB  : '0;
  assign MEM_output = out_valid ? out_entry.MEM : '0;

`ifdef EX_MEM_BRANCH_RESOLVE_EN
  assign pc_src_output    = out_valid && out_entry.MEM[MEM_BRANCH] && out_entry.alu_zero;
  assign pc_target_output = out_entry.pc_beq;
  assign drop_skid        = pc_src_output && out_ready;
`else
  assign drop_skid        = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: directed scenarios plus randomized traffic vs a queue model.
// Branch checks are active when EX_MEM_BRANCH_RESOLVE_EN is defined.
module tb_ex_mem_pipe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  wr;
    logic        z;
    logic [1:0]  wb;
    logic [2:0]  mem;
  } tb_entry_t;

  logic        clock = 1'b0;
  logic        startin;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_beq_input;
  logic [31:0] alu_result_input;
  logic [31:0] read_data_2_input;
  logic [4:0]  write_register_input;
  logic        alu_zero_input;
  logic [1:0]  WB_input;
  logic [2:0]  MEM_input;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_beq_output;
  logic [31:0] alu_result_output;
  logic [31:0] read_data_2_output;
  logic [4:0]  write_register_output;
  logic        alu_zero_output;
  logic [1:0]  WB_output;
  logic [2:0]  MEM_output;
`ifdef EX_MEM_BRANCH_RESOLVE_EN
  logic        pc_src_output;
  logic [31:0] pc_target_output;
`endif

  // Model: FIFO of held entries (front = main slot) and the last entry shown on the data outputs.
  tb_entry_t mq[$];
  tb_entry_t last_shown;
  int checks = 0;
  int failures = 0;

  tb_entry_t e1, e2, e3, eb;

  ex_mem_pipe_reg dut (
    .clock                (clock),
    .startin              (startin),
    .flush                (flush),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .pc_beq_input         (pc_beq_input),
    .alu_result_input     (alu_result_input),
    .read_data_2_input    (read_data_2_input),
    .write_register_input (write_register_input),
    .alu_zero_input       (alu_zero_input),
    .WB_input             (WB_input),
    .MEM_input            (MEM_input),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .pc_beq_output        (pc_beq_output),
    .alu_result_output    (alu_result_output),
    .read_data_2_output   (read_data_2_output),
    .write_register_output(write_register_output),
    .alu_zero_output      (alu_zero_output),
    .WB_output            (WB_output),
    .MEM_output           (MEM_output)
`ifdef EX_MEM_BRANCH_RESOLVE_EN
    ,
    .pc_src_output        (pc_src_output),
    .pc_target_output     (pc_target_output)
`endif
  );

  always #5 clock = ~clock;

  function automatic tb_entry_t observed();
    return {pc_beq_output, alu_result_output, read_data_2_output, write_register_output,
            alu_zero_output, WB_output, MEM_output};
  endfunction

  function automatic tb_entry_t expected();
    tb_entry_t e;
    if (mq.size() > 0) begin
      e = mq[0];
    end else begin
      e = last_shown;
      e.wb = '0;
      e.mem = '0;
    end
    return e;
  endfunction

  task automatic drive(input tb_entry_t e, input logic v);
    in_valid             = v;
    pc_beq_input         = e.pc;
    alu_result_input     = e.alu;
    read_data_2_input    = e.rd2;
    write_register_input = e.wr;
    alu_zero_input       = e.z;
    WB_input             = e.wb;
    MEM_input            = e.mem;
  endtask

  task automatic model_reset();
    mq.delete();
    last_shown = '0;
  endtask

  // Advance one clock and apply the same transfer rules to the model.
  task automatic tick();
    tb_entry_t in_e;
    logic acc, cons, fl;
    in_e = {pc_beq_input, alu_result_input, read_data_2_input, write_register_input,
            alu_zero_input, WB_input, MEM_input};
    acc  = in_valid && (mq.size() < 2);
    cons = (mq.size() > 0) && out_ready;
    fl   = flush;
    @(posedge clock);
    if (fl) begin
      mq.delete();
    end else begin
      if (cons) begin
`ifdef EX_MEM_BRANCH_RESOLVE_EN
        if (mq[0].mem[2] && mq[0].z) mq.delete();
        else void'(mq.pop_front());
`else
        void'(mq.pop_front());
`endif
      end
      if (acc) mq.push_back(in_e);
    end
    if (mq.size() > 0) last_shown = mq[0];
    #1;
  endtask

  task automatic hard_reset();
    startin = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive('0, 1'b0);
    model_reset();
    @(posedge clock);
    #1;
    startin = 1'b0;
  endtask

  task automatic test_reset();
    hard_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || observed() !== '0) begin
      failures++;
      $display("[TB] FAIL reset_init got v=%b r=%b out=%h want v=0 r=1 out=0", out_valid, in_ready, observed());
    end
    out_ready = 1'b0;
    drive(e1, 1'b1); tick();
    drive(e2, 1'b1); tick();
    drive('0, 1'b0);
    #3;
    startin = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || observed() !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid got v=%b r=%b out=%h want v=0 r=1 out=0", out_valid, in_ready, observed());
    end
    @(negedge clock);
    startin = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_no_replay got v=%b want v=0", out_valid);
    end
  endtask

  task automatic test_stream();
    hard_reset();
    out_ready = 1'b1;
    drive(e1, 1'b1); tick();
    checks++;
    if (out_valid !== 1'b1 || observed() !== e1) begin
      failures++;
      $display("[TB] FAIL stream_first got v=%b out=%h want v=1 out=%h", out_valid, observed(), e1);
    end
    drive(e2, 1'b1); tick();
    checks++;
    if (out_valid !== 1'b1 || observed() !== e2 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stream_second got v=%b r=%b out=%h want v=1 r=1 out=%h", out_valid, in_ready, observed(), e2);
    end
  endtask

  task automatic test_backpressure();
    hard_reset();
    out_ready = 1'b0;
    drive(e1, 1'b1); tick();
    checks++;
    if (in_ready !== 1'b1 || observed() !== e1) begin
      failures++;
      $display("[TB] FAIL bp_first got r=%b out=%h want r=1 out=%h", in_ready, observed(), e1);
    end
    drive(e2, 1'b1); tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || observed() !== e1) begin
      failures++;
      $display("[TB] FAIL bp_full got r=%b v=%b out=%h want r=0 v=1 out=%h", in_ready, out_valid, observed(), e1);
    end
    drive(e3, 1'b1);
    out_ready = 1'b1;
    tick();
    drive('0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || observed() !== e2) begin
      failures++;
      $display("[TB] FAIL bp_drain got v=%b out=%h want v=1 out=%h", out_valid, observed(), e2);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_empty got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    hard_reset();
    out_ready = 1'b0;
    drive(e1, 1'b1); tick();
    drive(e2, 1'b1); tick();
    drive(e3, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive('0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || WB_output !== 2'b00 || MEM_output !== 3'b000 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_bubble got v=%b wb=%b mem=%b r=%b want v=0 wb=00 mem=000 r=1",
               out_valid, WB_output, MEM_output, in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || pc_beq_output !== 32'h4) begin
      failures++;
      $display("[TB] FAIL flush_discard got v=%b pc=%h want v=0 pc=00000004", out_valid, pc_beq_output);
    end
  endtask

  task automatic test_bubble();
    tb_entry_t hold;
    hard_reset();
    out_ready = 1'b1;
    drive(e2, 1'b1); tick();
    drive('0, 1'b0);
    hold = e2;
    hold.wb = '0;
    hold.mem = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || observed() !== hold) begin
        failures++;
        $display("[TB] FAIL bubble_%0d got v=%b out=%h want v=0 out=%h", i, out_valid, observed(), hold);
      end
    end
  endtask

`ifdef EX_MEM_BRANCH_RESOLVE_EN
  task automatic test_branch();
    hard_reset();
    out_ready = 1'b0;
    drive(eb, 1'b1); tick();
    checks++;
    if (pc_src_output !== 1'b1 || pc_target_output !== 32'h8) begin
      failures++;
      $display("[TB] FAIL branch_taken got src=%b tgt=%h want src=1 tgt=00000008", pc_src_output, pc_target_output);
    end
    drive(e1, 1'b1); tick();
    drive('0, 1'b0);
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || pc_src_output !== 1'b0) begin
      failures++;
      $display("[TB] FAIL branch_drop got v=%b r=%b src=%b want v=0 r=1 src=0", out_valid, in_ready, pc_src_output);
    end
  endtask
`endif

  task automatic test_random();
    tb_entry_t r;
    hard_reset();
    for (int i = 0; i < 400; i++) begin
      r = {$urandom(), $urandom(), $urandom(), 5'($urandom()), 1'($urandom()), 2'($urandom()), 3'($urandom())};
      drive(r, ($urandom_range(0, 3) != 0));
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) || observed() !== expected()) begin
        failures++;
        $display("[TB] FAIL random_%0d got v=%b r=%b out=%h want v=%b r=%b out=%h", i, out_valid, in_ready,
                 observed(), (mq.size() > 0), (mq.size() < 2), expected());
      end
`ifdef EX_MEM_BRANCH_RESOLVE_EN
      checks++;
      if (pc_src_output !== ((mq.size() > 0) && mq[0].mem[2] && mq[0].z)) begin
        failures++;
        $display("[TB] FAIL random_src_%0d got %b want %b", i, pc_src_output,
                 ((mq.size() > 0) && mq[0].mem[2] && mq[0].z));
      end
`endif
    end
    flush = 1'b0;
  endtask

  initial begin
    e1 = {32'h4, 32'hA5A5A5A5, 32'h12345678, 5'h1F, 1'b0, 2'b10, 3'b101};
    e2 = {32'h8, 32'h5A5A5A5A, 32'h87654321, 5'h0F, 1'b1, 2'b01, 3'b011};
    e3 = {32'hC, 32'hFFFFFFFF, 32'h11111111, 5'h0A, 1'b0, 2'b11, 3'b110};
    eb = {32'h8, 32'h0, 32'h0, 5'h00, 1'b1, 2'b00, 3'b100};
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
`ifdef EX_MEM_BRANCH_RESOLVE_EN
    test_branch();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
